// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for four ultrasonic rangers sharing one sensor path.
// Latency: a distance is recorded and Done pulses the cycle after the echo fall, WAIT timeout or TMAX is sampled.
// Backpressure: none; Enable gates channel selection and aborts the owned measurement when its bit drops.
//
// Ports: Clock, Reset (async, active-low); Enable[3:0] channel mask; Threshold alarm distance;
//        Echo[3:0] synchronized echoes; Trig[3:0] one-hot trigger; DistBus 4x32 latest distances;
//        Alarm[3:0] debounced alarms; Chan owning channel; Done record strobe.
module ultrasonic_scheduler #(
    parameter int unsigned TTRIG  = 500,
    parameter int unsigned TWAIT  = 100000,
    parameter int unsigned TMAX   = 2000000,
    parameter int unsigned TGUARD = 5000000,
    parameter int unsigned HITS   = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [3:0]   Enable,
    input  logic [31:0]  Threshold,
    input  logic [3:0]   Echo,
    output logic [3:0]   Trig,
    output logic [127:0] DistBus,
    output logic [3:0]   Alarm,
    output logic [1:0]   Chan,
    output logic         Done
);

    localparam int HW = $clog2(HITS + 1);
    localparam logic [31:0] TIMEOUT_VAL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_GUARD
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          chan_nxt;
    logic [31:0]         tmr;
    logic [31:0]         cnt;
    logic                tmr_clr;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                rec_vld;
    logic [31:0]         rec_dat;
    logic [1:0]          rr_pick;
    logic                rr_found;
    logic                own_en;
    logic                own_echo;
    logic [3:0][HW-1:0]  hit_cnt;

    assign own_en   = Enable[Chan];
    assign own_echo = Echo[Chan];

    // Next enabled channel after Chan; k=4 wraps back to Chan itself, so it is tried last.
    always_comb begin
        rr_pick  = Chan;
        rr_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && Enable[Chan + 2'(k)]) begin
                rr_pick  = Chan + 2'(k);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        chan_nxt  = Chan;
        tmr_clr   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rec_vld   = 1'b0;
        rec_dat   = cnt;
        Trig      = 4'b0000;
        case (state)
            S_IDLE: begin
                if (Enable != 4'b0000) begin
                    chan_nxt  = rr_pick;
                    tmr_clr   = 1'b1;
                    state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                Trig[Chan] = 1'b1;
                if (!own_en) begin
                    tmr_clr   = 1'b1;
                    state_nxt = S_GUARD;
                end else if (tmr == TTRIG - 1) begin
                    tmr_clr   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!own_en) begin
                    tmr_clr   = 1'b1;
                    state_nxt = S_GUARD;
                end else if (own_echo) begin
                    // The rising-edge cycle only starts the measurement; it is not counted.
                    cnt_clr   = 1'b1;
                    state_nxt = S_MEAS;
                end else if (tmr == TWAIT - 1) begin
                    rec_vld   = 1'b1;
                    rec_dat   = TIMEOUT_VAL;
                    tmr_clr   = 1'b1;
                    state_nxt = S_GUARD;
                end
            end
            S_MEAS: begin
                if (!own_en) begin
                    tmr_clr   = 1'b1;
                    state_nxt = S_GUARD;
                end else if (own_echo) begin
                    // Reaching TMAX is a timeout, so cnt never exceeds TMAX-1 and never wraps.
                    if (cnt == TMAX - 1) begin
                        rec_vld   = 1'b1;
                        rec_dat   = TIMEOUT_VAL;
                        tmr_clr   = 1'b1;
                        state_nxt = S_GUARD;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    rec_vld   = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = S_GUARD;
                end
            end
            S_GUARD: begin
                if (tmr == TGUARD - 1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Chan    <= 2'd3;
            tmr     <= '0;
            cnt     <= '0;
            DistBus <= '0;
            Done    <= 1'b0;
        end else begin
            Chan <= chan_nxt;
            Done <= rec_vld;
            if (tmr_clr) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 32'd1;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 32'd1;
            end
            if (rec_vld) begin
                DistBus[{Chan, 5'd0} +: 32] <= rec_dat;
            end
        end
    end

    // Debounce: consecutive hits saturate at HITS; a disabled channel forgets its history.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hit_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!Enable[i]) begin
                    hit_cnt[i] <= '0;
                end else if (rec_vld && (Chan == 2'(i))) begin
                    if ((rec_dat != TIMEOUT_VAL) && (rec_dat < Threshold)) begin
                        if (hit_cnt[i] != HW'(HITS)) begin
                            hit_cnt[i] <= hit_cnt[i] + 1'b1;
                        end
                    end else begin
                        hit_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        Alarm = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            Alarm[i] = (hit_cnt[i] == HW'(HITS));
        end
    end

endmodule
